// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store memory controller: size codes, FSM
// states and the split-access decode helper.
package lsu_mem_ctrl_pkg;

    localparam logic [1:0] SIZ_BYTE = 2'b00;
    localparam logic [1:0] SIZ_HALF = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } lsu_state_e;

    typedef struct packed {
        logic [2:0] n;
        logic       mis;
    } split_info_t;

    // Any size code other than byte/half is treated as a word.
    function automatic split_info_t bytes_for(input logic [1:0] siz, input logic [1:0] addr_lo);
        split_info_t r;
        r.n   = 3'd1;
        r.mis = 1'b0;
        if (siz == SIZ_HALF) begin
            if (addr_lo[0]) begin
                r.n   = 3'd2;
                r.mis = 1'b1;
            end
        end else if (siz != SIZ_BYTE) begin
            if (addr_lo != 2'b00) begin
                r.n   = 3'd4;
                r.mis = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_split_decode.sv
// Combinational misalignment detection and RAM transaction count for a request.
module lsu_split_decode
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [1:0] siz,
    input  logic [1:0] addr_lo,
    output logic       misaligned,
    output logic [2:0] n_bytes
);

    split_info_t info;

    always_comb begin
        info       = bytes_for(siz, addr_lo);
        misaligned = info.mis;
        n_bytes    = info.n;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: forwards aligned accesses to the data RAM and splits
// misaligned ones into byte transactions, assembling loads little-endian.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_DM,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_siz,
    input  logic              req_se,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_split,
    output logic [ADDR_W-1:0] DM_Addr,
    output logic              RAM_Write,
    output logic [1:0]        siz,
    output logic              SE_s,
    output logic [31:0]       RAM_in,
    input  logic [31:0]       RAM_out
);

    lsu_state_e        state, state_nxt;
    logic              dec_mis;
    logic [2:0]        dec_n;
    logic              accept;
    logic [1:0]        cnt, cnt_inc, rd_idx;
    logic              we_p1, se_p1, mis_p1;
    logic [1:0]        siz_p1, last_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [31:0]       wdata_p1, asm_p1, asm_full, load_result;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic se);
        logic signed [15:0] hs;
        hs = h;
        return se ? 32'(hs) : {16'b0, h};
    endfunction

    lsu_split_decode u_dec (
        .siz        (req_siz),
        .addr_lo    (req_addr[1:0]),
        .misaligned (dec_mis),
        .n_bytes    (dec_n)
    );

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign cnt_inc    = cnt + 2'd1;
    assign rd_idx     = cnt - 2'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (cnt == last_p1) state_nxt = we_p1 ? RESP : DRAIN;
            DRAIN:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The last split byte arrives during DRAIN and is merged here, not from asm_p1.
    always_comb begin
        asm_full = asm_p1;
        asm_full[{last_p1, 3'b000} +: 8] = RAM_out[7:0];
        if (!mis_p1)
            load_result = RAM_out;
        else if (siz_p1 == SIZ_HALF)
            load_result = ext_half(asm_full[15:0], se_p1);
        else
            load_result = asm_full;
    end

    // Request capture (p1) and read-byte assembly
    always_ff @(posedge clk_DM) begin
        if (accept) begin
            we_p1    <= req_we;
            addr_p1  <= req_addr;
            siz_p1   <= req_siz;
            se_p1    <= req_se;
            wdata_p1 <= req_wdata;
            mis_p1   <= dec_mis;
            last_p1  <= 2'(dec_n - 3'd1);
        end
        if (state == ISSUE && !we_p1 && cnt != 2'd0)
            asm_p1[{rd_idx, 3'b000} +: 8] <= RAM_out[7:0];
    end

    always_ff @(posedge clk_DM) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            DM_Addr    <= '0;
            RAM_Write  <= 1'b0;
            siz        <= SIZ_BYTE;
            SE_s       <= 1'b0;
            RAM_in     <= 32'd0;
            resp_rdata <= 32'd0;
            resp_split <= 1'b0;
        end else begin
            state     <= state_nxt;
            RAM_Write <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    cnt       <= 2'd0;
                    DM_Addr   <= req_addr;
                    RAM_Write <= req_we;
                    if (dec_mis) begin
                        siz    <= SIZ_BYTE;
                        SE_s   <= 1'b0;
                        RAM_in <= {24'd0, req_wdata[7:0]};
                    end else begin
                        siz    <= req_siz;
                        SE_s   <= req_se;
                        RAM_in <= req_wdata;
                    end
                end
                ISSUE: if (cnt != last_p1) begin
                    cnt       <= cnt_inc;
                    DM_Addr   <= addr_p1 + ADDR_W'(cnt_inc);
                    RAM_Write <= we_p1;
                    RAM_in    <= {24'd0, byte_of(wdata_p1, cnt_inc)};
                end else if (we_p1) begin
                    resp_rdata <= 32'd0;
                    resp_split <= mis_p1;
                end
                DRAIN: begin
                    resp_rdata <= load_result;
                    resp_split <= mis_p1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl with a byte-array reference model and a
// behavioural data RAM that registers its read data.
module tb_lsu_mem_ctrl;

    logic        clk_DM = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [1:0]  req_siz = '0;
    logic        req_se = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_split;
    logic [7:0]  DM_Addr;
    logic        RAM_Write;
    logic [1:0]  siz;
    logic        SE_s;
    logic [31:0] RAM_in;
    logic [31:0] RAM_out;

    logic [7:0]  ram [256];
    logic [7:0]  sh [256];
    logic        fill = 1'b1;
    int          wr_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic        nxt_we, nxt_se;
    logic [7:0]  nxt_addr;
    logic [1:0]  nxt_siz;
    logic [31:0] nxt_wdata;

    always #5 clk_DM = ~clk_DM;

    lsu_mem_ctrl #(.ADDR_W(8)) dut (
        .clk_DM     (clk_DM),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_siz    (req_siz),
        .req_se     (req_se),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_split (resp_split),
        .DM_Addr    (DM_Addr),
        .RAM_Write  (RAM_Write),
        .siz        (siz),
        .SE_s       (SE_s),
        .RAM_in     (RAM_in),
        .RAM_out    (RAM_out)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    function automatic logic [31:0] ram_rd(input logic [7:0] a, input logic [1:0] s, input logic e);
        logic [31:0] w;
        w = {ram[8'(a + 8'd3)], ram[8'(a + 8'd2)], ram[8'(a + 8'd1)], ram[a]};
        case (s)
            2'b00:   return e ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
            2'b01:   return e ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk_DM) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
        end else if (RAM_Write) begin
            wr_cnt <= wr_cnt + 1;
            ram[DM_Addr] <= RAM_in[7:0];
            if (siz != 2'b00) ram[8'(DM_Addr + 8'd1)] <= RAM_in[15:8];
            if (siz[1]) begin
                ram[8'(DM_Addr + 8'd2)] <= RAM_in[23:16];
                ram[8'(DM_Addr + 8'd3)] <= RAM_in[31:24];
            end
        end
        RAM_out <= ram_rd(DM_Addr, siz, SE_s);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_mem(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== sh[i]) mism++;
        check(tag, mism, 0);
    endtask

    // One complete request; when hold is set the CPU keeps req_valid high
    // with churning fields and presents the nxt_* request once resp_valid shows.
    task automatic run_req(input logic we, input logic [7:0] a, input logic [1:0] sz,
                           input logic se, input logic [31:0] wd, input bit hold, input bit expect_now);
        int nb, n, lat, waitc, w0;
        bit mis;
        logic [31:0] exp;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        n   = mis ? nb : 1;
        exp = 32'd0;
        for (int k = 0; k < nb; k++) exp |= 32'(sh[8'(a + 8'(k))]) << (8 * k);
        if (we) exp = 32'd0;
        else if (sz == 2'b00 && se) exp = {{24{exp[7]}}, exp[7:0]};
        else if (sz == 2'b01 && se) exp = {{16{exp[15]}}, exp[15:0]};

        @(negedge clk_DM);
        req_valid = 1'b1; req_we = we; req_addr = a; req_siz = sz; req_se = se; req_wdata = wd;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk_DM);
            waitc++;
        end
        if (expect_now) check("accept_wait", waitc, 0);
        if (!req_ready) begin
            check("ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        w0 = wr_cnt;
        @(negedge clk_DM);
        check("c1_addr", DM_Addr, a);
        check("c1_siz", siz, mis ? 2'b00 : sz);
        if (!hold) req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk_DM);
            if (resp_valid) begin
                lat = c;
                break;
            end
            if (hold) begin
                req_addr = 8'($urandom); req_wdata = $urandom; req_we = 1'($urandom);
            end
        end
        if (hold) begin
            req_we = nxt_we; req_addr = nxt_addr; req_siz = nxt_siz; req_se = nxt_se; req_wdata = nxt_wdata;
        end
        check("latency", lat, we ? n + 1 : n + 2);
        check("rdata", resp_rdata, exp);
        check("split", resp_split, mis);
        check("writes", wr_cnt - w0, we ? n : 0);
        if (we) begin
            for (int k = 0; k < nb; k++) sh[8'(a + 8'(k))] = wd[8 * k +: 8];
            check_mem("mem");
        end
    endtask

    initial begin
        bit pend, h;
        for (int i = 0; i < 256; i++) sh[i] = init_byte(i);
        repeat (3) @(posedge clk_DM);
        fill = 1'b0;
        @(negedge clk_DM);
        check("rst_ready", req_ready, 0);
        check("rst_addr", DM_Addr, 0);
        check("rst_we", RAM_Write, 0);
        check("rst_siz", siz, 0);
        check("rst_se", SE_s, 0);
        check("rst_ramin", RAM_in, 0);
        check("rst_rvalid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_split", resp_split, 0);
        rst = 1'b0;
        @(negedge clk_DM);
        check("ready_after_rst", req_ready, 1);

        run_req(1'b1, 8'h04, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        run_req(1'b0, 8'h04, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
        run_req(1'b0, 8'h05, 2'b00, 1'b1, 32'h0, 1'b0, 1'b0);
        run_req(1'b0, 8'h05, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        run_req(1'b1, 8'h09, 2'b01, 1'b0, 32'h00008001, 1'b0, 1'b0);
        run_req(1'b0, 8'h09, 2'b01, 1'b1, 32'h0, 1'b0, 1'b0);
        run_req(1'b1, 8'hFE, 2'b10, 1'b0, 32'h11223344, 1'b0, 1'b0);
        run_req(1'b0, 8'hFE, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset two bytes into a wrapping split word store.
        run_req(1'b1, 8'hFE, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk_DM);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFE; req_siz = 2'b10; req_wdata = 32'h11223344;
        @(negedge clk_DM);
        req_valid = 1'b0;
        @(posedge clk_DM);
        #1 rst = 1'b1;
        @(negedge clk_DM);
        check("rst_mid_ready", req_ready, 0);
        @(negedge clk_DM);
        check("rst_mid_we", RAM_Write, 0);
        check("rst_mid_rvalid", resp_valid, 0);
        rst = 1'b0;
        @(negedge clk_DM);
        check("rst_mid_ready_back", req_ready, 1);
        h = 1'b0;
        for (int c = 0; c < 6; c++) begin
            h |= resp_valid;
            @(negedge clk_DM);
        end
        check("rst_mid_no_resp", h, 0);
        sh[8'hFE] = 8'h44;
        sh[8'hFF] = 8'h33;
        check_mem("rst_mid_mem");

        // Held request with churning fields while busy.
        nxt_we = 1'b0; nxt_addr = 8'h04; nxt_siz = 2'b10; nxt_se = 1'b0; nxt_wdata = 32'h0;
        run_req(1'b1, 8'h05, 2'b10, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0);
        run_req(nxt_we, nxt_addr, nxt_siz, nxt_se, nxt_wdata, 1'b0, 1'b1);

        pend = 1'b0;
        for (int i = 0; i < 150; i++) begin
            logic        rwe, rse;
            logic [7:0]  ra;
            logic [1:0]  rsz;
            logic [31:0] rwd;
            if (pend) begin
                rwe = nxt_we; ra = nxt_addr; rsz = nxt_siz; rse = nxt_se; rwd = nxt_wdata;
            end else begin
                rwe = 1'($urandom); ra = 8'($urandom); rsz = 2'($urandom); rse = 1'($urandom); rwd = $urandom;
            end
            h = ($urandom_range(0, 3) == 0);
            if (h) begin
                nxt_we = 1'($urandom); nxt_addr = 8'($urandom); nxt_siz = 2'($urandom);
                nxt_se = 1'($urandom); nxt_wdata = $urandom;
            end
            run_req(rwe, ra, rsz, rse, rwd, h, pend);
            pend = h;
        end
        if (pend) run_req(nxt_we, nxt_addr, nxt_siz, nxt_se, nxt_wdata, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
